// File: rtl/colorbar_gen.sv
// colorbar_gen: VGA-style timing generator with test patterns
// (colour bars, grey gradient, checkerboard, per-frame solid colour).
// Optional feature macro: COLORBAR_GRADIENT_EN enables the gradient
// pattern on mode 1; without it mode 1 renders colour bars.
// Sync, de and colour are registered one pixel after the hpos/vpos they
// describe; hpos/vpos are the live counter values.
module colorbar_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int NUM_BARS = 8,
  parameter int CBITS    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             invert,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CBITS-1:0] red,
  output logic [CBITS-1:0] green,
  output logic [CBITS-1:0] blue,
  output logic [9:0]       hpos,
  output logic [9:0]       vpos,
  output logic             frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Bar width is at least one pixel so the width counter always advances.
  localparam int         BAR_W_I  = ((H_ACTIVE / NUM_BARS) < 1) ? 1 : (H_ACTIVE / NUM_BARS);
  localparam logic [9:0] BAR_WEND = 10'(BAR_W_I - 1);
  localparam logic [9:0] BAR_MAX  = 10'(NUM_BARS - 1);

  // Map a 3-bit bar index to {R,G,B}, each channel all-ones or zero.
  function automatic logic [3*CBITS-1:0] bar_rgb(input logic [2:0] i);
    return {{CBITS{~i[1]}}, {CBITS{~i[2]}}, {CBITS{~i[0]}}};
  endfunction

  logic [9:0]         hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0]         bw_q, bw_d, bidx_q, bidx_d;
  logic [1:0]         mode_q, mode_d;
  logic               inv_q, inv_d;
  logic [8:0]         fcnt_q, fcnt_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CBITS-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [3*CBITS-1:0] rgb_sel;
  logic               active;
  logic               fs;

  // Frame start is the first pixel of a frame while running and out of reset.
  always_comb fs = ena && !rst && (hpos_q == 10'd0) && (vpos_q == 10'd0);

  // Pixel/line counters and the bar-width counter that tracks hpos.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    bw_d   = bw_q;
    bidx_d = bidx_q;
    if (ena) begin
      if (hpos_q == H_LAST) begin
        hpos_d = 10'd0;
        vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
      if (hpos_d == 10'd0) begin
        bw_d   = 10'd0;
        bidx_d = 10'd0;
      end else if (bw_q == BAR_WEND) begin
        bw_d = 10'd0;
        if (bidx_q != BAR_MAX) bidx_d = bidx_q + 10'd1;
      end else begin
        bw_d = bw_q + 10'd1;
      end
    end
  end

  // Mode, invert and frame count are captured only at frame start; the
  // _d values are used for the first pixel so the whole frame is consistent.
  always_comb begin
    mode_d = mode_q;
    inv_d  = inv_q;
    fcnt_d = fcnt_q;
    if (fs) begin
      mode_d = mode;
      inv_d  = invert;
      fcnt_d = fcnt_q + 9'd1;
    end
  end

`ifdef COLORBAR_GRADIENT_EN
  localparam int               GRAD_W_I  = ((H_ACTIVE >> CBITS) < 1) ? 1 : (H_ACTIVE >> CBITS);
  localparam logic [9:0]       GRAD_WEND = 10'(GRAD_W_I - 1);
  localparam logic [CBITS-1:0] GRAD_MAX  = '1;

  logic [9:0]       gw_q, gw_d;
  logic [CBITS-1:0] glvl_q, glvl_d;

  // Grey-level step counter, saturating at full scale, restarted each line.
  always_comb begin
    gw_d   = gw_q;
    glvl_d = glvl_q;
    if (ena) begin
      if (hpos_d == 10'd0) begin
        gw_d   = 10'd0;
        glvl_d = '0;
      end else if (gw_q == GRAD_WEND) begin
        gw_d = 10'd0;
        if (glvl_q != GRAD_MAX) glvl_d = glvl_q + 1'b1;
      end else begin
        gw_d = gw_q + 10'd1;
      end
    end
  end

  // Gradient state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gw_q   <= 10'd0;
      glvl_q <= '0;
    end else begin
      gw_q   <= gw_d;
      glvl_q <= glvl_d;
    end
  end
`endif

  // Pattern colour, sync windows and blanking for the current counter value.
  always_comb begin
    rgb_sel = '0;
    case (mode_d)
      2'd0: rgb_sel = bar_rgb(bidx_q[2:0]);
`ifdef COLORBAR_GRADIENT_EN
      2'd1: rgb_sel = {3{glvl_q}};
`else
      2'd1: rgb_sel = bar_rgb(bidx_q[2:0]);
`endif
      2'd2: rgb_sel = (hpos_q[5] ^ vpos_q[5]) ? '1 : '0;
      default: rgb_sel = bar_rgb(fcnt_d[8:6]);
    endcase
    if (inv_d) rgb_sel = ~rgb_sel;
    active = (hpos_q < H_ACT) && (vpos_q < V_ACT);
    if (!active) rgb_sel = '0;

    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (ena) begin
      hsync_d = !((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST));
      vsync_d = !((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST));
      de_d    = active;
      red_d   = rgb_sel[3*CBITS-1:2*CBITS];
      green_d = rgb_sel[2*CBITS-1:CBITS];
      blue_d  = rgb_sel[CBITS-1:0];
    end
  end

  // State and output registers; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      bw_q    <= 10'd0;
      bidx_q  <= 10'd0;
      mode_q  <= 2'd0;
      inv_q   <= 1'b0;
      fcnt_q  <= 9'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      bw_q    <= bw_d;
      bidx_q  <= bidx_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      fcnt_q  <= fcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_start = fs;

endmodule

// File: tb/tb_colorbar_gen.sv
// Directed bench for colorbar_gen: default horizontal timing, shortened
// vertical timing (36 active + 2 + 2 + 2 = 42 lines, 33600 cycles/frame).
module tb_colorbar_gen;

  logic       clk = 1'b0;
  logic       rst, ena, invert;
  logic [1:0] mode;
  logic       hsync, vsync, de, frame_start;
  logic [1:0] red, green, blue;
  logic [9:0] hpos, vpos;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cyc0   = 0;

  colorbar_gen #(
    .V_ACTIVE(36), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .invert(invert),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .hpos(hpos), .vpos(vpos), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v);
    bit found = 0;
    for (int i = 0; i < 40000; i++) begin
      if (hpos == h && vpos == v) begin
        found = 1;
        break;
      end
      step();
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_hv(%0d,%0d): timeout, at hpos=%0d vpos=%0d", h, v, hpos, vpos);
    end
  endtask

  task automatic test_reset();
    rst = 1; ena = 1; mode = 0; invert = 0;
    repeat (3) step();
    n_cmp++;
    if ({hpos, vpos, hsync, vsync, de, red, green, blue, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got h=%0d v=%0d hs=%b vs=%b de=%b rgb=%b fs=%b, want 0 0 1 1 0 000000 0",
               hpos, vpos, hsync, vsync, de, {red, green, blue}, frame_start);
    end
    rst = 0;
    #1;
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_fail++; $display("FAIL first_fs: got %b want 1", frame_start);
    end
    cyc0 = cyc;
  endtask

  task automatic test_bars();
    int         hs[5]   = '{79, 80, 160, 639, 640};
    logic [5:0] exp[5]  = '{6'b111111, 6'b111100, 6'b001111, 6'b000000, 6'b000000};
    logic       expd[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    step();
    n_cmp++;
    if ({de, red, green, blue} !== 7'b1111111) begin
      n_fail++; $display("FAIL bar_h0: got de=%b rgb=%b want 1 111111", de, {red, green, blue});
    end
    for (int k = 0; k < 5; k++) begin
      wait_hv(hs[k], 0);
      step();
      n_cmp++;
      if ({de, red, green, blue} !== {expd[k], exp[k]}) begin
        n_fail++;
        $display("FAIL bar_h%0d: got de=%b rgb=%b want de=%b rgb=%b", hs[k], de, {red, green, blue}, expd[k], exp[k]);
      end
    end
  endtask

  task automatic test_hsync();
    int lows = 0;
    wait_hv(656, 0);
    n_cmp++;
    if (hsync !== 1'b1) begin
      n_fail++; $display("FAIL hsync_before: got %b want 1", hsync);
    end
    step();
    n_cmp++;
    if (hsync !== 1'b0) begin
      n_fail++; $display("FAIL hsync_start: got %b want 0", hsync);
    end
    if (hsync === 1'b0) lows++;
    for (int i = 1; i < 100; i++) begin
      step();
      if (hsync === 1'b0) lows++;
    end
    n_cmp++;
    if (lows != 96) begin
      n_fail++; $display("FAIL hsync_width: got %0d want 96", lows);
    end
  endtask

  task automatic test_mode_switch_and_vsync();
    wait_hv(0, 20);
    mode = 2;
    wait_hv(80, 21);
    step();
    n_cmp++;
    if ({red, green, blue} !== 6'b111100) begin
      n_fail++; $display("FAIL midframe_bars: got %b want 111100", {red, green, blue});
    end
    wait_hv(0, 38);
    n_cmp++;
    if (vsync !== 1'b1) begin
      n_fail++; $display("FAIL vsync_before: got %b want 1", vsync);
    end
    step();
    n_cmp++;
    if ({vsync, de} !== 2'b00) begin
      n_fail++; $display("FAIL vsync_line38: got vs=%b de=%b want 0 0", vsync, de);
    end
    wait_hv(799, 39);
    step();
    n_cmp++;
    if (vsync !== 1'b0) begin
      n_fail++; $display("FAIL vsync_line39: got %b want 0", vsync);
    end
    wait_hv(0, 40);
    step();
    n_cmp++;
    if (vsync !== 1'b1) begin
      n_fail++; $display("FAIL vsync_after: got %b want 1", vsync);
    end
  endtask

  task automatic test_frame_spacing();
    bit seen = 0;
    for (int i = 0; i < 40000; i++) begin
      step();
      if (frame_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen || (cyc - cyc0) != 33600 || hpos != 0 || vpos != 0) begin
      n_fail++;
      $display("FAIL fs_spacing: got seen=%0d spacing=%0d at h=%0d v=%0d want 33600 at 0,0", seen, cyc - cyc0, hpos, vpos);
    end
    step();
    n_cmp++;
    if (frame_start !== 1'b0) begin
      n_fail++; $display("FAIL fs_single: got %b want 0", frame_start);
    end
  endtask

  task automatic test_checker();
    int         hs[3]  = '{32, 0, 32};
    int         vs[3]  = '{0, 32, 32};
    logic [5:0] exp[3] = '{6'b111111, 6'b111111, 6'b000000};
    n_cmp++;
    if ({red, green, blue} !== 6'b000000) begin
      n_fail++; $display("FAIL checker_0_0: got %b want 000000", {red, green, blue});
    end
    for (int k = 0; k < 3; k++) begin
      wait_hv(hs[k], vs[k]);
      step();
      n_cmp++;
      if ({red, green, blue} !== exp[k]) begin
        n_fail++;
        $display("FAIL checker_%0d_%0d: got %b want %b", hs[k], vs[k], {red, green, blue}, exp[k]);
      end
    end
  endtask

  task automatic test_ena_hold();
    int fs_cnt = 0;
    wait_hv(200, 33);
    ena = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (hpos !== 10'd200 || vpos !== 10'd33 || {de, red, green, blue} !== 7'b1111111 || fs_cnt != 0) begin
      n_fail++;
      $display("FAIL ena_hold: got h=%0d v=%0d de=%b rgb=%b fs=%0d want 200 33 1 111111 0",
               hpos, vpos, de, {red, green, blue}, fs_cnt);
    end
    ena = 1;
    step();
    n_cmp++;
    if (hpos !== 10'd201 || {red, green, blue} !== 6'b111111) begin
      n_fail++; $display("FAIL ena_resume: got h=%0d rgb=%b want 201 111111", hpos, {red, green, blue});
    end
  endtask

  task automatic test_reset_midframe();
    wait_hv(300, 34);
    rst = 1; mode = 3;
    step();
    n_cmp++;
    if ({hpos, vpos, hsync, vsync, de, red, green, blue, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: got h=%0d v=%0d hs=%b vs=%b de=%b rgb=%b fs=%b, want 0 0 1 1 0 000000 0",
               hpos, vpos, hsync, vsync, de, {red, green, blue}, frame_start);
    end
    ena = 0; rst = 0;
    #1;
    n_cmp++;
    if (frame_start !== 1'b0) begin
      n_fail++; $display("FAIL fs_ena_low: got %b want 0", frame_start);
    end
    step();
    ena = 1;
    #1;
    n_cmp++;
    if (hpos !== 10'd0 || frame_start !== 1'b1) begin
      n_fail++; $display("FAIL fs_after_rst: got h=%0d fs=%b want 0 1", hpos, frame_start);
    end
    step();
    n_cmp++;
    if (hpos !== 10'd1 || {red, green, blue} !== 6'b111111) begin
      n_fail++; $display("FAIL solid_h0: got h=%0d rgb=%b want 1 111111", hpos, {red, green, blue});
    end
    wait_hv(300, 0);
    step();
    n_cmp++;
    if ({red, green, blue} !== 6'b111111) begin
      n_fail++; $display("FAIL solid_h300: got %b want 111111", {red, green, blue});
    end
  endtask

  task automatic test_invert();
    int         hs[3]   = '{80, 160, 700};
    logic [5:0] exp[3]  = '{6'b000011, 6'b110000, 6'b000000};
    logic       expd[3] = '{1'b1, 1'b1, 1'b0};
    rst = 1;
    step();
    mode = 0; invert = 1; rst = 0;
    #1;
    step();
    invert = 0;
    n_cmp++;
    if ({de, red, green, blue} !== 7'b1000000) begin
      n_fail++; $display("FAIL inv_h0: got de=%b rgb=%b want 1 000000", de, {red, green, blue});
    end
    for (int k = 0; k < 3; k++) begin
      wait_hv(hs[k], 0);
      step();
      n_cmp++;
      if ({de, red, green, blue} !== {expd[k], exp[k]}) begin
        n_fail++;
        $display("FAIL inv_h%0d: got de=%b rgb=%b want de=%b rgb=%b", hs[k], de, {red, green, blue}, expd[k], exp[k]);
      end
    end
  endtask

  task automatic test_gradient();
    int         hs[3] = '{160, 480, 639};
    logic [5:0] exp[3];
    logic [5:0] exp0;
`ifdef COLORBAR_GRADIENT_EN
    exp0 = 6'b000000;
    exp  = '{6'b010101, 6'b111111, 6'b111111};
`else
    exp0 = 6'b111111;
    exp  = '{6'b001111, 6'b000011, 6'b000000};
`endif
    rst = 1;
    step();
    mode = 1; invert = 0; rst = 0;
    #1;
    step();
    n_cmp++;
    if ({red, green, blue} !== exp0) begin
      n_fail++; $display("FAIL mode1_h0: got %b want %b", {red, green, blue}, exp0);
    end
    for (int k = 0; k < 3; k++) begin
      wait_hv(hs[k], 0);
      step();
      n_cmp++;
      if ({red, green, blue} !== exp[k]) begin
        n_fail++; $display("FAIL mode1_h%0d: got %b want %b", hs[k], {red, green, blue}, exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_hsync();
    test_mode_switch_and_vsync();
    test_frame_spacing();
    test_checker();
    test_ena_hold();
    test_reset_midframe();
    test_invert();
    test_gradient();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/colorbar_gen.md
COLORBAR_GEN -- requirements
Module: colorbar_gen

Interface
REQ-001 Parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: the same vertical timing, in lines.
REQ-004 Parameter NUM_BARS, 8: bars across the active width; 1..H_ACTIVE.
REQ-005 Parameter CBITS, 2: bits per colour channel; 1..8.
REQ-006 clk  input  1  pixel clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ena  input  1  advance enable; low freezes all state.
REQ-009 mode  input  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 solid cycle.
REQ-010 invert  input  1  complement all active-video colour bits.
REQ-011 hsync, vsync  output  1 each  active-low sync pulses.
REQ-012 de  output  1  active-video flag.
REQ-013 red, green, blue  output  CBITS each  pixel colour.
REQ-014 hpos, vpos  output  10 each  current counter values.
REQ-015 frame_start  output  1  one-cycle pulse at hpos=0, vpos=0.

Function
REQ-016 Counters: hpos wraps at H_ACTIVE+H_FP+H_SYNC+H_BP-1 to 0; on that wrap vpos increments, wrapping at its own total-1 to 0.
REQ-017 hsync is low for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync uses the equivalent vertical window.
REQ-018 de is high for hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-019 Latency: hsync, vsync, de and the colour outputs are registered, 1 cycle after the hpos/vpos they describe.
REQ-020 Blanking: colour outputs are 0 whenever de=0, regardless of invert.
REQ-021 Bar index: a width counter steps the index every H_ACTIVE/NUM_BARS (integer) pixels; the index saturates at NUM_BARS-1, so remainder pixels belong to the last bar; both reset at hpos=0.
REQ-022 Bar colour uses i = bar index mod 8: R=~i[1], G=~i[2], B=~i[0]; a 1 maps to all-ones, 0 to zero. Sequence: white, yellow, cyan, green, magenta, red, blue, black.
REQ-023 Gradient: a grey level steps every H_ACTIVE>>CBITS pixels, saturates at 2^CBITS-1 and resets at hpos=0; all channels equal the level.
REQ-024 Checker: white if hpos[5]^vpos[5] is 1, else black.
REQ-025 Solid cycle: a 9-bit frame counter increments at each frame_start; the whole screen uses bar colour i = counter[8:6].
REQ-026 mode and invert are sampled only when frame_start is generated; mid-frame changes take effect at the next frame.
REQ-027 ena=0: counters, frame counter and all outputs hold; frame_start is forced to 0.
REQ-028 frame_start is never high for two consecutive cycles.

Reset
REQ-029 rst=1 at a clock edge sets hpos=vpos=0, hsync=vsync=1, de=0, colour=0, frame_start=0, latched mode=0, latched invert=0 and frame counter=0; it has priority over ena.
REQ-030 The first cycle with rst=0 and ena=1 generates frame_start and samples mode and invert.

Configuration
REQ-031 Macro COLORBAR_GRADIENT_EN: when defined, mode 1 is the gradient of REQ-023. When undefined, the gradient logic is absent and mode 1 renders as mode 0 (bars).

Verification
REQ-032 Defaults, reset, ena=1, mode=0: colour 1 cycle after hpos=0 is (3,3,3); after hpos=80, (3,3,0); after hpos=639, (0,0,0); after hpos=640, de=0 and colour 0.
REQ-033 Timing: hsync low for exactly 96 cycles starting 1 cycle after hpos=656; vsync low for lines 490-491; frame_start spacing 420000 cycles.
REQ-034 Switch mode 0->2 at vpos=100: bars continue to the frame end; next frame: (0,0) gives black, (32,0) white, (32,32) black.
REQ-035 mode=1 with the macro defined: level 0 at hpos 0, 1 at 160, 3 at 480-639; without the macro: identical to mode 0.
REQ-036 Assert rst at hpos=300, vpos=200: next cycle all outputs at reset values; after release, frame_start fires and hpos counts from 0.
REQ-037 Drop ena for 100 cycles mid-line: hpos, vpos and colour unchanged, no frame_start; resume continues from the same hpos.
